// File: rtl/serial_paralelo_align_pkg.sv
// Shared constants and types for the serial/parallel link: comma symbol, word width, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_paralelo_align_pkg;
  localparam logic [7:0] COMMA_SYM = 8'hBC;
  localparam int         W         = 9;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sp_state_t;
endpackage

// File: rtl/serial_paralelo_align_if.sv
// Bit-pair input and recovered-word outputs of the receive aligner.
// Latency: none (wiring only).
// Backpressure: none; the aligner pushes words out on a strobe.
// Optional loss_cnt signal exists only when SP_LOSSCNT_EN is defined.
interface serial_paralelo_align_if;
  import serial_paralelo_align_pkg::*;

  logic [1:0]   serial;
  logic [W-1:0] outParalelo;
  logic         word_stb;
  logic         locked;
`ifdef SP_LOSSCNT_EN
  logic [7:0]   loss_cnt;
`endif

  modport master (
    output serial,
    input  outParalelo, word_stb, locked
`ifdef SP_LOSSCNT_EN
    , input loss_cnt
`endif
  );

  modport slave (
    input  serial,
    output outParalelo, word_stb, locked
`ifdef SP_LOSSCNT_EN
    , output loss_cnt
`endif
  );
endinterface

// File: rtl/serial_paralelo_align_comma_window.sv
// 8-bit sliding window over the incoming bit pairs plus the comma compare.
// Latency: pair sampled at edge E is in o_sr after E; o_is_comma is combinational on o_sr.
// Backpressure: none; shifts every cycle.
module serial_paralelo_align_comma_window #(
  parameter logic [7:0] COMMA = 8'hBC
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_serial,
  output logic [7:0] o_sr,
  output logic       o_is_comma
);
  logic [7:0] r_sr;

  // Shift the newest pair into the low end; the oldest pair falls off the top.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sr <= 8'h00;
    else         r_sr <= {r_sr[5:0], i_serial};
  end

  assign o_sr       = r_sr;
  assign o_is_comma = (r_sr == COMMA);
endmodule

// File: rtl/serial_paralelo_align.sv
// Finds the byte boundary of a 2-bit serial stream via idle commas, tracks lock, emits {valid,data} words.
// Latency: last pair of a byte sampled at edge E -> outParalelo/word_stb updated at edge E+1.
// Backpressure: none; one strobe per 4 cycles while locked. Option macro: SP_LOSSCNT_EN (loss_cnt port).
module serial_paralelo_align
  import serial_paralelo_align_pkg::*;
#(
  parameter logic [7:0]  COMMA       = COMMA_SYM,
  parameter int unsigned LOCK_COMMAS = 4,
  parameter int unsigned MAX_RUN     = 64
) (
  input  logic                    clk16f,
  input  logic                    reset,
  serial_paralelo_align_if.slave  bus
);
  localparam int RW = $clog2(MAX_RUN + 1);

  sp_state_t    r_state;
  logic [1:0]   r_ph;
  logic [3:0]   r_ccnt;
  logic [RW-1:0] r_run;
  logic [W-1:0] r_out;
  logic         r_stb;
  logic         r_locked;
`ifdef SP_LOSSCNT_EN
  logic [7:0]   r_loss;
`endif

  logic [7:0] w_sr;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_ccnt_inc;
  logic       w_run_over;

  serial_paralelo_align_comma_window #(.COMMA(COMMA)) u_window (
    .i_clk      (clk16f),
    .i_reset    (reset),
    .i_serial   (bus.serial),
    .o_sr       (w_sr),
    .o_is_comma (w_is_comma)
  );

  assign w_boundary = (r_ph == 2'd0);
  assign w_ccnt_inc = r_ccnt + 4'd1;
  // run never exceeds MAX_RUN, so run+1 > MAX_RUN is exactly run == MAX_RUN.
  assign w_run_over = (r_run == RW'(MAX_RUN));

  // Alignment FSM with phase, comma/run counters and registered outputs.
  always_ff @(posedge clk16f) begin
    if (reset) begin
      r_state  <= SEARCH;
      r_ph     <= 2'd0;
      r_ccnt   <= 4'd0;
      r_run    <= '0;
      r_out    <= '0;
      r_stb    <= 1'b0;
      r_locked <= 1'b0;
`ifdef SP_LOSSCNT_EN
      r_loss   <= 8'h00;
`endif
    end else begin
      r_stb <= 1'b0;
      r_ph  <= r_ph + 2'd1;
      case (r_state)
        SEARCH: begin
          // Any pair offset may hold a comma; that cycle becomes the boundary.
          if (w_is_comma) begin
            r_ph   <= 2'd1;
            r_ccnt <= 4'd1;
            if (LOCK_COMMAS == 1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_run    <= '0;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              r_ccnt <= w_ccnt_inc;
              if (w_ccnt_inc == 4'(LOCK_COMMAS)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_run    <= '0;
              end
            end else begin
              r_state <= SEARCH;
              r_ccnt  <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              r_out <= '0;
              r_run <= '0;
              r_stb <= 1'b1;
            end else if (w_run_over) begin
              // Too long without a comma: drop lock, swallow this byte.
              r_state  <= SEARCH;
              r_locked <= 1'b0;
              r_ccnt   <= 4'd0;
`ifdef SP_LOSSCNT_EN
              if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
`endif
            end else begin
              r_out <= {1'b1, w_sr};
              r_run <= r_run + RW'(1);
              r_stb <= 1'b1;
            end
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign bus.outParalelo = r_out;
  assign bus.word_stb    = r_stb;
  assign bus.locked      = r_locked;
`ifdef SP_LOSSCNT_EN
  assign bus.loss_cnt    = r_loss;
`endif
endmodule

// File: tb/tb_serial_paralelo_align.sv
// Scoreboard bench for serial_paralelo_align: directed byte streams, expected words queued at send time.
// Latency checked: strobe must appear one edge after the edge sampling a byte's last pair.
// Optional loss counter checks are compiled in with SP_LOSSCNT_EN.
module tb_serial_paralelo_align;
  import serial_paralelo_align_pkg::*;

  logic clk16f = 1'b0;
  logic reset  = 1'b1;

  serial_paralelo_align_if bus();

  serial_paralelo_align dut (
    .clk16f (clk16f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk16f = ~clk16f;

  typedef struct {
    logic [8:0] dat;
    int         cyc;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk16f) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Queue the word expected from the byte whose last pair was just sampled.
  task automatic push(input logic [8:0] d, input string tag);
    exp_t e;
    e.dat = d;
    e.cyc = cyc + 1;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Send one byte MSB pair first; optionally check locked after its first pair.
  task automatic send_byte(input logic [7:0] b, input int lk, input string tag);
    for (int k = 0; k < 4; k++) begin
      bus.serial = b[7-2*k -: 2];
      @(posedge clk16f); #1;
      if (k == 0 && lk >= 0) chk({tag, "_locked"}, 9'(bus.locked), 9'(lk));
    end
  endtask

  task automatic send_pair(input logic [1:0] p);
    bus.serial = p;
    @(posedge clk16f); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out"},    bus.outParalelo,    9'h000);
    chk({tag, "_stb"},    9'(bus.word_stb),   9'h000);
    chk({tag, "_locked"}, 9'(bus.locked),     9'h000);
  endtask

  // One idle pair lets any pending strobe land, then a one-cycle reset.
  task automatic reset_pulse(input string tag);
    send_pair(2'b00);
    reset = 1'b1;
    @(posedge clk16f); #1;
    check_idle_outputs(tag);
`ifdef SP_LOSSCNT_EN
    chk({tag, "_loss"}, 9'(bus.loss_cnt), 9'h000);
`endif
    reset = 1'b0;
    bus.serial = 2'b00;
  endtask

  // Monitor: every strobe must match the head of the queue in data and timing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk16f); #1;
      if (bus.word_stb === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got outParalelo=%h, want no strobe", bus.outParalelo);
        end else begin
          e = q.pop_front();
          total++;
          if (bus.outParalelo !== e.dat) begin
            bad++;
            $display("FAIL %s data: got %h want %h", e.tag, bus.outParalelo, e.dat);
          end
          total++;
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL %s latency: strobe at cycle %0d want %0d", e.tag, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    bus.serial = 2'(($urandom_range(0, 3)));

    // Reset held three cycles with random serial, then one cycle after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk16f); #1;
      bus.serial = 2'(($urandom_range(0, 3)));
      check_idle_outputs("reset_hold");
    end
    reset = 1'b0;
    bus.serial = 2'b00;
    @(posedge clk16f); #1;
    check_idle_outputs("reset_after");

    // Lock at pair offset 0, then two data bytes.
    for (int i = 0; i < 4; i++) send_byte(COMMA_SYM, -1, "lock_comma");
    send_byte(8'h5A, 1, "lock_5a");   push(9'h15A, "lock_5a");
    send_byte(8'h3C, 1, "lock_3c");   push(9'h13C, "lock_3c");
    send_byte(COMMA_SYM, 1, "lock_idle"); push(9'h000, "lock_idle");

    // Misaligned lock: one junk pair shifts the boundary by one pair.
    reset_pulse("rst_mis");
    send_pair(2'b01);
    for (int i = 0; i < 4; i++) send_byte(COMMA_SYM, -1, "mis_comma");
    send_byte(8'hA5, 1, "mis_a5");    push(9'h1A5, "mis_a5");
    send_byte(COMMA_SYM, 1, "mis_idle"); push(9'h000, "mis_idle");

    // Abort: two commas then data drop back to search; four fresh commas lock.
    reset_pulse("rst_abort");
    send_byte(COMMA_SYM, -1, "abort_c1");
    send_byte(COMMA_SYM, -1, "abort_c2");
    send_byte(8'h11, 0, "abort_11");
    for (int i = 0; i < 4; i++) send_byte(COMMA_SYM, (i == 0) ? 0 : -1, "abort_comma");
    send_byte(8'h42, 1, "abort_42");  push(9'h142, "abort_42");
    send_byte(COMMA_SYM, 1, "abort_idle"); push(9'h000, "abort_idle");

    // Run loss: 64 data bytes strobe, the 65th drops lock without a strobe.
    for (int i = 0; i < 65; i++) begin
      send_byte(8'(i + 1), (i == 64) ? 1 : -1, "run_hold");
      if (i < 64) push(9'h100 | 9'(i + 1), "run");
    end
    send_byte(8'h00, 0, "run_loss");
`ifdef SP_LOSSCNT_EN
    chk("run_loss_cnt", 9'(bus.loss_cnt), 9'h001);
`endif

    // Idle commas while locked give zero words; reset mid-byte clears everything.
    for (int i = 0; i < 4; i++) send_byte(COMMA_SYM, -1, "idle_comma");
    send_byte(COMMA_SYM, 1, "idle_c");  push(9'h000, "idle_c");
    send_byte(8'h66, 1, "idle_66");     push(9'h166, "idle_66");
    send_pair(2'b01);
    send_pair(2'b01);
    reset_pulse("rst_mid");
    for (int i = 0; i < 3; i++) send_byte(COMMA_SYM, (i == 0) ? 0 : -1, "relock_comma");
    send_byte(COMMA_SYM, 0, "relock_c4");
    send_byte(8'h77, 1, "relock_77");   push(9'h177, "relock_77");
    send_byte(COMMA_SYM, 1, "relock_idle"); push(9'h000, "relock_idle");
    reset_pulse("rst_end");

    repeat (3) @(posedge clk16f);
    #1;
    chk("queue_drained", 9'(q.size()), 9'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
